ysyx_22040237_ifu_fetch: RTL

Instruction fetch stage that sits directly upstream of the decode stage. It owns the fetch PC, issues word requests to instruction memory over a valid/ready request channel, and collects in-order responses into a small FIFO. It presents instructions to decode as `inst`/`inst_pc` with a valid/ready handshake. Redirects from execute (branch, jump, trap) flush the stream, and responses still in flight from the old path are discarded.

---
 rtl/ysyx_22040237_ifu_fetch.sv | 115 +++++++++++
 1 files changed

// File: rtl/ysyx_22040237_ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to imem,
// and queues in-order responses for decode. Redirects flush and drop stale responses.
module ysyx_22040237_ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_fault
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } entry_t;

   entry_t        fifo_q [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] drop_cnt;
   logic [31:0]   fpc;
   logic [31:0]   rsp_pc;
   logic          fault_stop;

   logic          pop;
   logic          accept;
   logic          push;
   logic          credit;
   logic [CW:0]   pending;
   logic [31:0]   target_pc;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign inst_valid = (count != '0);
   assign inst       = fifo_q[rd_ptr].inst;
   assign inst_pc    = fifo_q[rd_ptr].pc;
   assign inst_fault = fifo_q[rd_ptr].fault;

   assign pop = inst_valid & inst_ready;

   // Every outstanding request must have a FIFO slot reserved, counting the slot freed this cycle.
   assign pending = (CW+1)'(out_cnt) + (CW+1)'(count) - (CW+1)'(pop);
   assign credit  = (pending < (CW+1)'(DEPTH));

   assign imem_req_valid = rst & credit & ~halt & ~fault_stop & ~redirect_valid;
   assign imem_req_addr  = fpc;
   assign accept         = imem_req_valid & imem_req_ready;

   assign push      = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;
   assign target_pc = redirect_pc & ~32'h3;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc        <= RESET_PC;
         rsp_pc     <= RESET_PC;
         out_cnt    <= '0;
         drop_cnt   <= '0;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fault_stop <= 1'b0;
         // NOTE: the entry array is reset because the head is a direct view of it
         // and must read as zero out of reset; it is small enough for flops.
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         out_cnt <= out_cnt + CW'(accept) - CW'(imem_rsp_valid);
         if (redirect_valid) begin
            fpc        <= target_pc;
            rsp_pc     <= target_pc;
            fault_stop <= 1'b0;
            drop_cnt   <= out_cnt - CW'(imem_rsp_valid);
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
         end else begin
            if (accept) fpc <= fpc + 32'd4;
            if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            if (push) begin
               fifo_q[wr_ptr] <= '{pc:    rsp_pc,
                                   inst:  imem_rsp_err ? 32'h0 : imem_rsp_data,
                                   fault: imem_rsp_err};
               wr_ptr         <= bump(wr_ptr);
               rsp_pc         <= rsp_pc + 32'd4;
               if (imem_rsp_err) fault_stop <= 1'b1;
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

endmodule
